// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM states, client index, read burst default.
package mem_arb_pkg;

   localparam int unsigned READ_BEATS_DEF = 4;

   typedef enum logic [1:0] {
      IDLE,
      WRITE_DATA,
      READ_RESP
   } state_t;

   typedef logic client_idx_t;

endpackage

// File: rtl/mem_arb_select.sv
// Two-input winner selector: a lone requester wins; on a tie the pointed-to client wins.
module mem_arb_select
   import mem_arb_pkg::*;
(
   input  logic [1:0]  valid,
   input  client_idx_t ptr,
   output logic [1:0]  grant
);

   always_comb begin
      grant = valid;
      if (valid[0] && valid[1]) begin
         grant      = '0;
         grant[ptr] = 1'b1;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between icache (client 0) and dcache (client 1), one transaction per grant.
// Define ARB_ROUND_ROBIN_EN for alternating priority; otherwise client 0 wins every tie.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W     = 28,
   parameter int unsigned DATA_W     = 128,
   parameter int unsigned TAG_W      = 5,
   parameter int unsigned READ_BEATS = READ_BEATS_DEF
) (
   input  logic                clk,
   input  logic                reset,

   input  logic                c0_req_valid,
   output logic                c0_req_ready,
   input  logic                c0_req_rw,
   input  logic [ADDR_W-1:0]   c0_req_addr,
   input  logic [TAG_W-1:0]    c0_req_tag,
   input  logic                c0_req_data_valid,
   output logic                c0_req_data_ready,
   input  logic [DATA_W-1:0]   c0_req_data_bits,
   input  logic [DATA_W/8-1:0] c0_req_data_mask,
   output logic                c0_resp_valid,
   output logic [DATA_W-1:0]   c0_resp_data,
   output logic [TAG_W-1:0]    c0_resp_tag,

   input  logic                c1_req_valid,
   output logic                c1_req_ready,
   input  logic                c1_req_rw,
   input  logic [ADDR_W-1:0]   c1_req_addr,
   input  logic [TAG_W-1:0]    c1_req_tag,
   input  logic                c1_req_data_valid,
   output logic                c1_req_data_ready,
   input  logic [DATA_W-1:0]   c1_req_data_bits,
   input  logic [DATA_W/8-1:0] c1_req_data_mask,
   output logic                c1_resp_valid,
   output logic [DATA_W-1:0]   c1_resp_data,
   output logic [TAG_W-1:0]    c1_resp_tag,

   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic                mem_req_rw,
   output logic [ADDR_W-1:0]   mem_req_addr,
   output logic [TAG_W-1:0]    mem_req_tag,
   output logic                mem_req_data_valid,
   input  logic                mem_req_data_ready,
   output logic [DATA_W-1:0]   mem_req_data_bits,
   output logic [DATA_W/8-1:0] mem_req_data_mask,
   input  logic                mem_resp_valid,
   input  logic [DATA_W-1:0]   mem_resp_data,
   input  logic [TAG_W-1:0]    mem_resp_tag
);

   localparam int unsigned CNT_W = (READ_BEATS > 1) ? $clog2(READ_BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(READ_BEATS - 1);

   state_t           state, state_nxt;
   client_idx_t      owner, owner_nxt;
   logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;
   client_idx_t      ptr;
   logic [1:0]       grant;
   client_idx_t      win;
   logic             req_hs, data_hs, last_beat;

   mem_arb_select u_select (
      .valid (                       {c1_req_valid, c0_req_valid}),
      .ptr   (ptr),
      .grant (grant)
   );

   assign win = grant[1];

   // Request fields follow the winner; only the valid/ready pair is state-gated.
   assign mem_req_rw   = win ? c1_req_rw   : c0_req_rw;
   assign mem_req_addr = win ? c1_req_addr : c0_req_addr;
   assign mem_req_tag  = win ? c1_req_tag  : c0_req_tag;
   assign mem_req_data_bits = owner ? c1_req_data_bits : c0_req_data_bits;
   assign mem_req_data_mask = owner ? c1_req_data_mask : c0_req_data_mask;

   assign req_hs    = (state == IDLE) && (|grant) && mem_req_ready;
   assign data_hs   = (state == WRITE_DATA) && mem_req_data_valid && mem_req_data_ready;
   assign last_beat = (state == READ_RESP) && mem_resp_valid && (beat_cnt == LAST_BEAT);

   assign c0_resp_valid = mem_resp_valid && (state == READ_RESP) && (owner == 1'b0);
   assign c1_resp_valid = mem_resp_valid && (state == READ_RESP) && (owner == 1'b1);
   assign c0_resp_data  = mem_resp_data;
   assign c1_resp_data  = mem_resp_data;
   assign c0_resp_tag   = mem_resp_tag;
   assign c1_resp_tag   = mem_resp_tag;

   always_comb begin
      state_nxt          = state;
      owner_nxt          = owner;
      beat_cnt_nxt       = beat_cnt;
      mem_req_valid      = 1'b0;
      c0_req_ready       = 1'b0;
      c1_req_ready       = 1'b0;
      mem_req_data_valid = 1'b0;
      c0_req_data_ready  = 1'b0;
      c1_req_data_ready  = 1'b0;
      case (state)
         IDLE: begin
            mem_req_valid = |grant;
            c0_req_ready  = grant[0] && mem_req_ready;
            c1_req_ready  = grant[1] && mem_req_ready;
            if (req_hs) begin
               owner_nxt    = win;
               beat_cnt_nxt = '0;
               state_nxt    = mem_req_rw ? WRITE_DATA : READ_RESP;
            end
         end
         WRITE_DATA: begin
            mem_req_data_valid = owner ? c1_req_data_valid : c0_req_data_valid;
            c0_req_data_ready  = (owner == 1'b0) && mem_req_data_ready;
            c1_req_data_ready  = (owner == 1'b1) && mem_req_data_ready;
            if (data_hs)
               state_nxt = IDLE;
         end
         READ_RESP: begin
            if (mem_resp_valid)
               beat_cnt_nxt = beat_cnt + 1'b1;
            if (last_beat)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         owner    <= 1'b0;
         beat_cnt <= '0;
      end else begin
         state    <= state_nxt;
         owner    <= owner_nxt;
         beat_cnt <= beat_cnt_nxt;
      end
   end

`ifdef ARB_ROUND_ROBIN_EN
   always_ff @(posedge clk) begin
      if (reset)
         ptr <= 1'b0;
      else if (data_hs || last_beat)
         ptr <= ~owner;
   end
`else
   assign ptr = 1'b0;
`endif

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-client arbiter that shares the single backup memory port between the instruction cache (client 0) and data cache (client 1). It multiplexes request, write-data and response channels. A grant is held for one whole memory transaction: one write-data beat, or READ_BEATS read-response beats. The block sits between the two cache refill/writeback ports and the memory model, adding no cycles of latency on any path.

## Interface
Parameters:
- ADDR_W, 28, request address width
- DATA_W, 128, data beat width; mask width DATA_W/8
- TAG_W, 5, tag width; tags pass through unmodified
- READ_BEATS, 4, response beats per read transaction

Ports (N = 0, 1; one line per client-side signal pair):
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- cN_req_valid  in  1  client request valid
- cN_req_ready  out  1  client request accepted
- cN_req_rw  in  1  1 = write, 0 = read
- cN_req_addr  in  ADDR_W  request address
- cN_req_tag  in  TAG_W  request tag
- cN_req_data_valid  in  1  write beat valid
- cN_req_data_ready  out  1  write beat accepted
- cN_req_data_bits  in  DATA_W  write data
- cN_req_data_mask  in  DATA_W/8  byte enables
- cN_resp_valid  out  1  read beat for this client
- cN_resp_data  out  DATA_W  response data, shared by both clients
- cN_resp_tag  out  TAG_W  response tag, shared by both clients
- mem_req_valid/ready/rw/addr/tag  out/in/out/out/out  1/1/1/ADDR_W/TAG_W  memory request channel
- mem_req_data_valid/ready/bits/mask  out/in/out/out  1/1/DATA_W/DATA_W/8  memory write-data channel
- mem_resp_valid/data/tag  in  1/DATA_W/TAG_W  memory response channel

## Operation
State machine: IDLE, WRITE_DATA, READ_RESP. Registers: owner (1 bit), beat counter (ceil log2 READ_BEATS bits), priority pointer (1 bit).

IDLE:
- Combinationally select a winner from the cN_req_valid signals.
- Drive the mem_req_* signals from the winner only. mem_req_valid = winner's valid.
- cN_req_ready = mem_req_ready for the winner only; 0 for the loser.
- On a mem_req handshake:
  - latch owner;
  - go to WRITE_DATA if rw = 1, else go to READ_RESP with the beat counter cleared.

WRITE_DATA:
- mem_req_valid = 0.
- The write-data channel connects to the owner only; the non-owner sees cN_req_data_ready = 0.
- On the data handshake, go to IDLE.

READ_RESP:
- mem_req_valid = 0. The write-data channel is disconnected.
- Each mem_resp_valid beat increments the counter.
- The beat that brings the count to READ_BEATS returns the machine to IDLE on the next edge.

Response routing:
- cN_resp_valid = mem_resp_valid & (state == READ_RESP) & (owner == N).
- mem_resp_valid seen in any other state is dropped.
- resp data/tag fan out to both clients unchanged.

Other rules:
- The write-data channel is never forwarded in IDLE or READ_RESP. mem_req_data_valid = 0 there.
- Every transaction ends with a return to IDLE; no grant is issued in the same cycle a transaction ends.
- Priority pointer: updated only when a transaction completes. It points to the client that did not own that transaction.

## Timing
- Reset values:
  - state IDLE, beat counter 0, pointer = client 0;
  - all cN_req_ready, cN_req_data_ready, cN_resp_valid, mem_req_valid and mem_req_data_valid low.
- The arbiter adds zero cycles to any path. Request, data and response paths are purely combinational through the arbiter.
- Read latency: with the memory accepting in cycle t, beats arrive at t+1..t+4. The state is IDLE again at t+5.
- Write latency: with the data handshake in cycle t, the state is IDLE at t+1.
- Simultaneous valid from both clients in IDLE: the client favoured by the priority rule wins. The loser keeps its valid asserted and sees ready = 0.
- Reset mid-transaction: abort immediately; return to IDLE with pointer and counter reset. The memory shares the same reset.
- Response beats need not be consecutive. The counter counts only asserted mem_resp_valid beats.

## Configuration
- ARB_ROUND_ROBIN_EN defined: the pointer alternates priority after every completed transaction.
- ARB_ROUND_ROBIN_EN undefined:
  - fixed priority, client 0 (icache) always wins ties;
  - the pointer register is not built.

## Structure
- Package mem_arb_pkg holds:
  - the state enum (IDLE, WRITE_DATA, READ_RESP);
  - the READ_BEATS default;
  - the client index type.
- One sub-module, mem_arb_select: a two-input priority/round-robin winner selector. Inputs are the two valids and the pointer. Output is a one-hot grant.

## Test plan
- c0 read at addr 0x100, tag 3, memory returns 4 beats: c0_resp_valid high for exactly 4 cycles with tag 3; c1_resp_valid stays 0; state is IDLE after the 4th beat.
- c1 write to addr 0x40 with mask 0xFFFF, data beat delayed 3 cycles: mem_req_data_valid stays 0 until c1 asserts its data valid; a single data handshake returns the state to IDLE; c0 data ready is never asserted.
- Both clients request reads every cycle with the macro defined: grants alternate c0, c1, c0, c1. Without the macro, c0 wins every tie and c1 is held.
- c1 request arrives during a c0 read: c1_req_ready stays 0 until c0's 4th beat; c1 is granted the cycle after at the earliest.
- Reset asserted after the 2nd read beat: next cycle all outputs are low, state IDLE, pointer favours c0; a new c1 read completes normally.
- Spurious mem_resp_valid while in IDLE: no cN_resp_valid is asserted and the counter is unchanged.
